regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: port 0 for ALU results, port 1 for load data. It also keeps a 32-entry busy scoreboard that the issue stage checks before reading source operands. It sits between the execute/memory writeback paths and the register file. It produces one registered write per cycle and a combinational read-after-write hazard stall.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, register index width (2**ADDR_W registers; index 0 is hard-wired zero)

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset; synchronous, active-high
- wb0_valid_i  in  1  ALU writeback request
- wb0_rd_i  in  ADDR_W  ALU destination
- wb0_data_i  in  DATA_W  ALU result
- wb0_ready_o  out  1  ALU request accepted this cycle
- wb1_valid_i, wb1_rd_i, wb1_data_i, wb1_ready_o  same as port 0, for load writeback
- issue_valid_i  in  1  an instruction with a destination issues this cycle
- issue_rd_i  in  ADDR_W  destination of the issuing instruction
- rs1_i, rs2_i  in  ADDR_W  source indices of the instruction in issue
- valid_src1_i, valid_src2_i  in  1  source operand actually used
- stall_o  out  1  source hazard; combinational
- rf_we_o  out  1  register file write enable; registered
- rf_waddr_o  out  ADDR_W  write address; registered
- rf_wdata_o  out  DATA_W  write data; registered
- busy_o  out  2**ADDR_W  scoreboard bit vector; registered

## Operation
- A handshake completes on a port in a cycle when its valid_i and ready_o are both high.
- A requester holds valid, rd and data stable until accepted.
- Arbitration is round-robin and uses a 1-bit priority pointer with two states:
  - PRI0: port 0 wins a conflict.
  - PRI1: port 1 wins a conflict.
- Arbitration rules:
  - Only one port valid: that port gets ready=1; the pointer is unchanged.
  - Both ports valid: the favoured port gets ready=1, the other gets ready=0, and the pointer flips to favour the loser.
  - Neither port valid: both ready=0; the pointer is unchanged.
- ready_o never asserts without the same port's valid_i.
- Accepted write with rd≠0: rf_we_o=1, rf_waddr_o=rd, rf_wdata_o=data in the following cycle.
- Accepted write with rd=0: the handshake completes, but rf_we_o stays 0 and the scoreboard is untouched.
- Scoreboard set: issue_valid_i with issue_rd_i≠0 sets busy[issue_rd_i].
- Scoreboard clear: an accepted write clears busy[rd] at the edge where rf_we_o's write commits, one cycle after acceptance.
- Set and clear of the same index on the same edge: set wins, because the new producer supersedes the old one.
- busy[0] is always 0.
- stall_o = (valid_src1_i & rs1_i≠0 & busy[rs1_i]) | (valid_src2_i & rs2_i≠0 & busy[rs2_i]).
- No data bypass; the stall covers the whole hazard window.

## Timing
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0, pointer=PRI0.
- Reset also forces wb0_ready_o, wb1_ready_o and stall_o to 0 while rst_i is high.
- Reset mid-operation: in-flight accepted writes are dropped, and no rf_we_o pulse is issued on the cycle after reset deasserts.
- Acceptance-to-write latency is 1 cycle.
- Throughput is one write per cycle.
- A losing requester waits at most 1 cycle under continuous contention.
- Accept in cycle N → rf_we_o in cycle N+1 → busy clears at the end of N+1 → stall_o drops in cycle N+2.
- rf_we_o is a single-cycle pulse per accepted rd≠0 write.
- Back-to-back accepts give consecutive pulses.

## Structure
- Shared package holds: DATA_W/ADDR_W defaults, the REG_ZERO constant, and the arbiter pointer enum (PRI0, PRI1).
- One sub-module: regfile_scoreboard (busy vector, set/clear priority, stall logic).
- Arbitration and the write-port register stay in the top level.

## Test plan
- Reset: hold rst_i 2 cycles with both valids high → both ready=0, rf_we_o=0, busy_o=0; pointer=PRI0 afterwards.
- Single write: wb0 valid, rd=5, data=0xDEADBEEF in cycle N → wb0_ready=1 in N; rf_we_o=1, waddr=5, wdata=0xDEADBEEF in N+1; idle in N+2.
- Contention: both valid for 4 cycles, with rd=3/data=0x11 on port 0 and rd=4/data=0x22 on port 1, each port re-presenting the same request until accepted then presenting a new one → grants alternate 0,1,0,1; writes appear 0x11, 0x22, 0x11, 0x22 in order.
- Hazard: issue rd=7 → busy[7]=1. Then:
  - rs1=7 with valid_src1 → stall_o=1.
  - Write rd=7 accepted in cycle N → stall_o=0 in N+2.
  - rs1=7 with valid_src1=0 → stall_o=0 throughout.
- Same-edge conflict and x0:
  - Issue rd=9 on the edge where an older rd=9 write commits → busy[9] stays 1.
  - Write rd=0 → handshake completes, rf_we_o stays 0.
  - Issue rd=0 → busy_o unchanged.
- Mid-operation reset: accept a write in cycle N with rst_i high in N+1 → no rf_we_o pulse and all busy bits 0 after reset.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and types for the register-file write arbiter and its scoreboard.
package regfile_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Which writeback port wins the next conflict.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue, cleared on writeback.
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_idx,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_idx,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    input  logic                 src1_used,
    input  logic                 src2_used,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [2**ADDR_W-1:0] busy_next;
    logic                 hit1;
    logic                 hit2;

    // Set is applied after clear: a newly issued producer supersedes the retiring one.
    always_comb begin
        busy_next = busy;
        if (clr_en)
            busy_next[clr_idx] = 1'b0;
        if (set_en && set_idx != ZERO)
            busy_next[set_idx] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign hit1  = src1_used && rs1 != ZERO && busy[rs1];
    assign hit2  = src2_used && rs2 != ZERO && busy[rs2];
    assign stall = !rst && (hit1 || hit2);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of ALU/load writebacks onto the single register-file write port.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb0_valid_i,
    input  logic [ADDR_W-1:0]    wb0_rd_i,
    input  logic [DATA_W-1:0]    wb0_data_i,
    output logic                 wb0_ready_o,
    input  logic                 wb1_valid_i,
    input  logic [ADDR_W-1:0]    wb1_rd_i,
    input  logic [DATA_W-1:0]    wb1_data_i,
    output logic                 wb1_ready_o,
    input  logic                 issue_valid_i,
    input  logic [ADDR_W-1:0]    issue_rd_i,
    input  logic [ADDR_W-1:0]    rs1_i,
    input  logic [ADDR_W-1:0]    rs2_i,
    input  logic                 valid_src1_i,
    input  logic                 valid_src2_i,
    output logic                 stall_o,
    output logic                 rf_we_o,
    output logic [ADDR_W-1:0]    rf_waddr_o,
    output logic [DATA_W-1:0]    rf_wdata_o,
    output logic [2**ADDR_W-1:0] busy_o
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    pri_e              ptr;
    logic              conflict;
    logic              accept;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              we_q;

    assign conflict    = wb0_valid_i && wb1_valid_i;
    assign wb0_ready_o = !rst_i && wb0_valid_i && (!wb1_valid_i || ptr == PRI0);
    assign wb1_ready_o = !rst_i && wb1_valid_i && (!wb0_valid_i || ptr == PRI1);
    assign accept      = wb0_ready_o || wb1_ready_o;
    assign sel_rd      = wb1_ready_o ? wb1_rd_i   : wb0_rd_i;
    assign sel_data    = wb1_ready_o ? wb1_data_i : wb0_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr        <= PRI0;
            we_q       <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            if (conflict)
                ptr <= (ptr == PRI0) ? PRI1 : PRI0;
            we_q <= accept && sel_rd != ZERO;
            if (accept && sel_rd != ZERO) begin
                rf_waddr_o <= sel_rd;
                rf_wdata_o <= sel_data;
            end
        end
    end

    // A write accepted just before reset asserts must not reach the register file.
    assign rf_we_o = we_q && !rst_i;

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk       (clk_i),
        .rst       (rst_i),
        .set_en    (issue_valid_i),
        .set_idx   (issue_rd_i),
        .clr_en    (rf_we_o),
        .clr_idx   (rf_waddr_o),
        .rs1       (rs1_i),
        .rs2       (rs2_i),
        .src1_used (valid_src1_i),
        .src2_used (valid_src2_i),
        .stall     (stall_o),
        .busy      (busy_o)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          wb0_valid_i = 1'b0, wb1_valid_i = 1'b0;
    logic [AW-1:0] wb0_rd_i = '0, wb1_rd_i = '0;
    logic [DW-1:0] wb0_data_i = '0, wb1_data_i = '0;
    logic          wb0_ready_o, wb1_ready_o;
    logic          issue_valid_i = 1'b0;
    logic [AW-1:0] issue_rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic          valid_src1_i = 1'b0, valid_src2_i = 1'b0;
    logic          stall_o, rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic [NR-1:0] busy_o;

    always #5 clk_i = ~clk_i;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb0_valid_i(wb0_valid_i), .wb0_rd_i(wb0_rd_i), .wb0_data_i(wb0_data_i), .wb0_ready_o(wb0_ready_o),
        .wb1_valid_i(wb1_valid_i), .wb1_rd_i(wb1_rd_i), .wb1_data_i(wb1_data_i), .wb1_ready_o(wb1_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .valid_src1_i(valid_src1_i), .valid_src2_i(valid_src2_i),
        .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Behavioural model state
    bit [NR-1:0] m_busy;
    int          fav;
    bit          pend;
    int          pend_rd;

    // Staged stimulus, applied just after each rising edge
    bit            rv[2];
    logic [AW-1:0] rrd[2];
    logic [DW-1:0] rdat[2];
    bit            acc[2];
    bit            s_rst = 1'b1, s_iv = 1'b0, s_v1 = 1'b0, s_v2 = 1'b0;
    logic [AW-1:0] s_ird = '0, s_rs1 = '0, s_rs2 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit e0, e1, es;
        int p;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (rst_i) begin
            chk("rdy0_rst", 64'(wb0_ready_o), 64'd0);
            chk("rdy1_rst", 64'(wb1_ready_o), 64'd0);
            chk("stall_rst", 64'(stall_o), 64'd0);
            chk("we_rst", 64'(rf_we_o), 64'd0);
            chk("busy", 64'(busy_o), 64'(m_busy));
            m_busy = '0;
            fav    = 0;
            pend   = 1'b0;
            exp_q.delete();
            return;
        end
        e0 = wb0_valid_i && (!wb1_valid_i || fav == 0);
        e1 = wb1_valid_i && (!wb0_valid_i || fav == 1);
        es = (valid_src1_i && rs1_i != 0 && m_busy[rs1_i]) || (valid_src2_i && rs2_i != 0 && m_busy[rs2_i]);
        chk("rdy0", 64'(wb0_ready_o), 64'(e0));
        chk("rdy1", 64'(wb1_ready_o), 64'(e1));
        chk("stall", 64'(stall_o), 64'(es));
        chk("busy", 64'(busy_o), 64'(m_busy));
        chk("we", 64'(rf_we_o), 64'(pend));
        if (pend) m_busy[pend_rd] = 1'b0;
        if (issue_valid_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
        if (wb0_valid_i && wb1_valid_i) fav = 1 - fav;
        pend = 1'b0;
        if (e0 || e1) begin
            p = e0 ? 0 : 1;
            acc[p] = 1'b1;
            rv[p]  = 1'b0;
            if (rrd[p] != 0) begin
                pend    = 1'b1;
                pend_rd = int'(rrd[p]);
                exp_q.push_back('{rd: rrd[p], data: rdat[p]});
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        rst_i         = s_rst;
        wb0_valid_i   = rv[0]; wb0_rd_i = rrd[0]; wb0_data_i = rdat[0];
        wb1_valid_i   = rv[1]; wb1_rd_i = rrd[1]; wb1_data_i = rdat[1];
        issue_valid_i = s_iv;  issue_rd_i = s_ird;
        rs1_i = s_rs1; rs2_i = s_rs2; valid_src1_i = s_v1; valid_src2_i = s_v2;
        s_iv = 1'b0;
        @(negedge clk_i);
        model_step();
    endtask

    task automatic req(input int p, input int rd, input logic [DW-1:0] d);
        rv[p]   = 1'b1;
        rrd[p]  = AW'(rd);
        rdat[p] = d;
    endtask

    task automatic issue(input int rd);
        s_iv  = 1'b1;
        s_ird = AW'(rd);
    endtask

    // Write-port monitor: every pulse must match the oldest outstanding accepted write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk_i);
            if (rf_we_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected none", rf_waddr_o, rf_wdata_o);
                end else begin
                    w = exp_q.pop_front();
                    chk("waddr", 64'(rf_waddr_o), 64'(w.rd));
                    chk("wdata", 64'(rf_wdata_o), 64'(w.data));
                end
            end
        end
    end

    initial begin
        int grants[4];
        rv[0] = 1'b0; rv[1] = 1'b0;
        rrd[0] = '0; rrd[1] = '0; rdat[0] = '0; rdat[1] = '0;
        m_busy = '0; fav = 0; pend = 1'b0; pend_rd = 0;

        // Reset held with both requesters valid
        req(0, 1, 32'hAAAA_0001);
        req(1, 2, 32'hBBBB_0002);
        s_rst = 1'b1;
        cycle();
        cycle();
        s_rst = 1'b0;
        rv[0] = 1'b0; rv[1] = 1'b0;
        cycle();

        // Single write, then idle
        req(0, 5, 32'hDEAD_BEEF);
        cycle();
        chk("single_acc", 64'(acc[0]), 64'd1);
        cycle();
        chk("single_we", 64'(rf_we_o), 64'd1);
        chk("single_addr", 64'(rf_waddr_o), 64'd5);
        chk("single_data", 64'(rf_wdata_o), 64'hDEAD_BEEF);
        cycle();

        // Continuous contention alternates grants
        for (int i = 0; i < 4; i++) begin
            req(0, 3, 32'h11);
            req(1, 4, 32'h22);
            cycle();
            grants[i] = acc[0] ? 0 : 1;
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        for (int i = 0; i < 4; i++)
            chk("grant_order", 64'(grants[i]), 64'(i % 2));
        cycle();
        cycle();

        // RAW hazard on x7
        issue(7);
        cycle();
        s_rs1 = 5'd7; s_v1 = 1'b1;
        cycle();
        chk("busy7", 64'(busy_o[7]), 64'd1);
        chk("stall7", 64'(stall_o), 64'd1);
        s_v1 = 1'b0;
        cycle();
        chk("stall7_unused", 64'(stall_o), 64'd0);
        s_v1 = 1'b1;
        req(1, 7, 32'h7777_0007);
        cycle();
        cycle();
        chk("stall7_n1", 64'(stall_o), 64'd1);
        cycle();
        chk("stall7_n2", 64'(stall_o), 64'd0);
        s_v1 = 1'b0;

        // Reissue of x9 on the edge its older write commits
        issue(9);
        cycle();
        req(0, 9, 32'h9999_0009);
        cycle();
        issue(9);
        cycle();
        cycle();
        chk("busy9_kept", 64'(busy_o[9]), 64'd1);

        // Writes and issues targeting x0
        req(0, 0, 32'hFFFF_FFFF);
        cycle();
        chk("x0_acc", 64'(acc[0]), 64'd1);
        cycle();
        chk("x0_no_we", 64'(rf_we_o), 64'd0);
        issue(0);
        cycle();
        cycle();
        chk("x0_busy", 64'(busy_o[0]), 64'd0);

        // Reset right after an accept
        issue(12);
        cycle();
        req(0, 6, 32'h6666_0006);
        cycle();
        s_rst = 1'b1;
        cycle();
        chk("mid_rst_we", 64'(rf_we_o), 64'd0);
        cycle();
        s_rst = 1'b0;
        cycle();
        chk("mid_rst_we_after", 64'(rf_we_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++)
                if (!rv[p] && $urandom_range(0, 2) != 0)
                    req(p, int'($urandom_range(0, 15)), DW'($urandom));
            if ($urandom_range(0, 1) == 1) issue(int'($urandom_range(0, 15)));
            s_rs1 = AW'($urandom_range(0, 15));
            s_rs2 = AW'($urandom_range(0, 15));
            s_v1  = 1'($urandom_range(0, 1));
            s_v2  = 1'($urandom_range(0, 1));
            s_rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        s_rst = 1'b0;
        rv[0] = 1'b0; rv[1] = 1'b0;
        s_v1 = 1'b0; s_v2 = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
